freq_counter_mc: RTL
====================

# freq_counter_mc

Multi-channel gated frequency counter for the Cyclone IV tester. Counts edges on up to N_CHANNELS asynchronous chip outputs over one common, programmable gate window. Each measurement is started by a single-cycle handshake, and all channel results are latched together at the end of the window. It succeeds the single-channel edge counter, and adds per-channel enables, selectable edge mode, overflow flags and a latched result bank.

## Interface
Parameters:
- DATA_WIDTH, 16, width of each per-channel edge counter and result.
- GATE_WIDTH, 24, width of the gate-length counter and `gate_cycles`.
- N_CHANNELS, 4, number of measured inputs (≥1).
- SYNC_STAGES, 2, synchronizer flops per input (≥2).

Ports (one clock; reset is asynchronous and active-low):
- Clock  in  1  system clock.
- nReset  in  1  asynchronous active-low reset.
- start  in  1  request a measurement; sampled only in IDLE.
- gate_cycles  in  GATE_WIDTH  gate length in Clock cycles; latched on accepted start.
- chan_en  in  N_CHANNELS  per-channel enable; latched on accepted start.
- both_edges  in  1  0 = count rising edges, 1 = count rising and falling edges; latched on accepted start.
- in_wave  in  N_CHANNELS  asynchronous measured signals.
- busy  out  1  high in ARM and GATE.
- done  out  1  one-cycle pulse in DONE; results valid from this cycle.
- edge_count  out  N_CHANNELS*DATA_WIDTH  latched results; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- overflow  out  N_CHANNELS  latched per-channel counter-overflow flags.

## Operation
- States: IDLE, ARM, GATE, DONE.
- IDLE: when start=1, latch gate_cycles, chan_en and both_edges, then go to ARM. Otherwise stay in IDLE.
- ARM (1 cycle): clear the working counters and sticky overflow bits. If latched gate=0, go to DONE. Otherwise reset the gate counter to 0 and go to GATE.
- GATE: the gate counter increments every cycle. Edge pulses on enabled channels increment their working counters. When gate counter = gate−1, go to DONE. The window is therefore exactly gate cycles.
- DONE (1 cycle): `done`=1. Result registers are loaded from the working counters and overflow bits on the GATE/ARM→DONE transition edge. Then go to IDLE.
- Results and overflow hold their values until the next DONE.
- Edge detect per channel: a SYNC_STAGES-flop synchronizer feeds a delay flop `d`. Edge pulse = s & ~d in rising mode, or s ^ d in both-edges mode. The detector runs in every state; pulses count only in GATE.
- A disabled channel reports edge_count=0 and overflow=0.
- Overflow: an edge arriving while the working counter is all-ones sets that channel's sticky overflow bit. The counter then wraps to 0 (see Configuration).
- start is ignored in ARM, GATE and DONE. There is no queuing.
- nReset asserted at any time, including mid-GATE, forces:
  - state IDLE;
  - busy=0, done=0;
  - edge_count=0, overflow=0;
  - all counters and synchronizers to 0.

## Timing
- Reset values: busy=0, done=0, edge_count all 0, overflow all 0.
- start high at edge t (IDLE):
  - ARM in cycle t+1;
  - GATE in cycles t+2 … t+G+1;
  - DONE/done=1 in cycle t+G+2.
- Back-to-back: the earliest next accepted start is the cycle after DONE (IDLE at t+G+3). Total period is G+3 cycles.
- G=0: done in cycle t+2, all results 0.
- Pin-to-pulse latency is SYNC_STAGES+1 Clock edges. An input transition counts if its edge pulse falls inside the GATE cycles.
- Input frequency must be below Clock/2 (rising mode) or Clock/4 (both-edges mode) for exact counts.

## Configuration
- FREQ_MC_SATURATE_EN defined: on overflow, the working counter holds at all-ones (2^DATA_WIDTH−1) and overflow is set.
- FREQ_MC_SATURATE_EN undefined: the counter wraps modulo 2^DATA_WIDTH and overflow is set.
- Behaviour is otherwise identical in both builds.

## Test plan
- Reset mid-GATE: assert nReset during GATE -> busy=0, done=0, all outputs 0 immediately. A new start after release behaves normally.
- 4 channels, Clock period 10 ns, in_wave periods 40/80/160/320 ns, gate=1000, rising mode, all enabled -> done at t+1002; counts 250/125/62–63/31–32 (±1 for phase); overflow=0.
- Same stimulus with both_edges=1 and chan_en=4'b0101 -> ch0 ≈500, ch1=0, ch2 ≈125, ch3=0; overflow=0.
- DATA_WIDTH=4, ch0 at 40 ns period, gate=100 -> 25 edges. Result is 9 without the macro, or 15 with FREQ_MC_SATURATE_EN; overflow[0]=1 in both.
- gate=0 -> done at t+2, edge_count=0. start held high continuously -> a new measurement every G+3 cycles, and start is never accepted while busy=1.

Source files
------------

// File: rtl/freq_counter_mc.sv
// freq_counter_mc: multi-channel gated edge counter.
// A single start handshake opens a common gate window of gate_cycles clocks.
// Each enabled channel counts synchronized edges (rising, or both) during the
// window. All results and overflow flags are latched together when the
// window closes and stay valid until the next measurement ends.
// Build option: define FREQ_MC_SATURATE_EN to make the working counters
// saturate at all-ones on overflow. When it is not defined they wrap.
module freq_counter_mc #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned GATE_WIDTH  = 24,
    parameter int unsigned N_CHANNELS  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                             Clock,
    input  logic                             nReset,
    input  logic                             start,
    input  logic [GATE_WIDTH-1:0]            gate_cycles,
    input  logic [N_CHANNELS-1:0]            chan_en,
    input  logic                             both_edges,
    input  logic [N_CHANNELS-1:0]            in_wave,
    output logic                             busy,
    output logic                             done,
    output logic [N_CHANNELS*DATA_WIDTH-1:0] edge_count,
    output logic [N_CHANNELS-1:0]            overflow
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

    state_t                                  state_q;
    logic [GATE_WIDTH-1:0]                   gate_q;
    logic [GATE_WIDTH-1:0]                   gcnt_q;
    logic [N_CHANNELS-1:0]                   en_q;
    logic                                    both_q;
    logic                                    busy_q;
    logic                                    done_q;

    logic [SYNC_STAGES-1:0][N_CHANNELS-1:0]  sync_q;
    logic [N_CHANNELS-1:0]                   dly_q;
    logic [N_CHANNELS-1:0]                   pulse;

    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0]   cnt_q, cnt_d;
    logic [N_CHANNELS-1:0]                   ovf_q, ovf_d;
    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0]   res_q;
    logic [N_CHANNELS-1:0]                   res_ovf_q;

    logic                                    gate_last;
    logic                                    to_done;

    assign busy       = busy_q;
    assign done       = done_q;
    assign edge_count = res_q;
    assign overflow   = res_ovf_q;

    // Edge pulse from the last synchronizer stage and its delayed copy
    always_comb begin
        pulse = both_q ? (sync_q[SYNC_STAGES-1] ^ dly_q)
                       : (sync_q[SYNC_STAGES-1] & ~dly_q);
    end

    // Window end detection: last GATE cycle, or an empty window straight from ARM
    always_comb begin
        gate_last = (gcnt_q == (gate_q - GATE_WIDTH'(1)));
        to_done   = ((state_q == S_ARM) && (gate_q == '0)) ||
                    ((state_q == S_GATE) && gate_last);
    end

    // Input synchronizers and edge-detect delay flop, running in every state
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            sync_q[0] <= in_wave;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Next value of the working counters and sticky overflow bits
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (state_q == S_ARM) begin
            cnt_d = '0;
            ovf_d = '0;
        end else if (state_q == S_GATE) begin
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
                if (en_q[i] && pulse[i]) begin
                    if (&cnt_q[i]) begin
                        ovf_d[i] = 1'b1;
`ifdef FREQ_MC_SATURATE_EN
                        cnt_d[i] = cnt_q[i];
`else
                        cnt_d[i] = '0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + DATA_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Working counter registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Control FSM with registered busy/done and the latched result bank
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            gate_q    <= '0;
            gcnt_q    <= '0;
            en_q      <= '0;
            both_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= '0;
        end else begin
            done_q <= 1'b0;
            // Results take the next-state counters so the final GATE cycle's edges are included
            if (to_done) begin
                res_q     <= cnt_d;
                res_ovf_q <= ovf_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        gate_q  <= gate_cycles;
                        en_q    <= chan_en;
                        both_q  <= both_edges;
                        busy_q  <= 1'b1;
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    gcnt_q <= '0;
                    if (gate_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_GATE;
                    end
                end
                S_GATE: begin
                    gcnt_q <= gcnt_q + GATE_WIDTH'(1);
                    if (gate_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
